// File: rtl/alu_arith_pipe.sv
// -----------------------------------------------------------------------------
// alu_arith_pipe
//
// Registered arithmetic/compare unit behind a valid/ready request port and a
// valid/ready result port. Single-cycle ops (ADD, SUB, set-compare) deliver
// their result one cycle after acceptance at a throughput of one per cycle.
// An optional multi-cycle unsigned shift-add multiplier is included when the
// macro ALU_ARITH_MUL_EN is defined; without it opcode 0100 is illegal and the
// FSM stays in IDLE.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its request (and the block holds its result)
// stable until that edge; ready never depends combinationally on valid of the
// same port.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   request accepted this cycle
//   in1, in2   operands (two's complement)
//   crtlSig    opcode
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out        result
//   cout       carry out (SUB: 1 = no borrow)
//   overflow   signed overflow (MUL: upper product bits nonzero)
//   illegal    unknown opcode
//   state_dbg  current FSM state (IDLE=0, MUL=1, DONE=2)
//
// Configuration macro: ALU_ARITH_MUL_EN
// -----------------------------------------------------------------------------
module alu_arith_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       crtlSig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SEQ = 4'b0001;
  localparam logic [3:0] OP_SNE = 4'b1001;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SGT = 4'b0011;
  localparam logic [3:0] OP_SLE = 4'b1101;
  localparam logic [3:0] OP_SGE = 4'b1011;
`ifdef ALU_ARITH_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0100;
`endif

  state_t           state;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] res_out;
  logic             res_cout;
  logic             res_ovf;
  logic             res_ill;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             lt;
  logic             eq;

  assign in_ready  = (~out_valid | out_ready) & (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign state_dbg = state;

  // SUB is in1 + ~in2 + 1 so the carry out doubles as the no-borrow flag.
  assign add_full = {1'b0, in1} + {1'b0, in2};
  assign sub_full = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
  assign lt       = $signed(in1) < $signed(in2);
  assign eq       = (in1 == in2);

  // Result of a single-cycle op, computed from the live request so it can be
  // registered on the accepting edge.
  always_comb begin
    res_out  = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    res_ill  = 1'b0;
    is_mul   = 1'b0;
    case (crtlSig)
      OP_ADD: begin
        res_out  = add_full[WIDTH-1:0];
        res_cout = add_full[WIDTH];
        res_ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                   (add_full[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_out  = sub_full[WIDTH-1:0];
        res_cout = sub_full[WIDTH];
        res_ovf  = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                   (sub_full[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SEQ: res_out = {{(WIDTH-1){1'b0}}, eq};
      OP_SNE: res_out = {{(WIDTH-1){1'b0}}, ~eq};
      OP_SLT: res_out = {{(WIDTH-1){1'b0}}, lt};
      OP_SGT: res_out = {{(WIDTH-1){1'b0}}, ~lt & ~eq};
      OP_SLE: res_out = {{(WIDTH-1){1'b0}}, lt | eq};
      OP_SGE: res_out = {{(WIDTH-1){1'b0}}, ~lt};
`ifdef ALU_ARITH_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: res_ill = 1'b1;
    endcase
  end

`ifdef ALU_ARITH_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  // Low half starts as the multiplier and is shifted out one bit per cycle
  // while the partial product grows into the high half.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     psum;

  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`else
  assign state = IDLE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_ARITH_MUL_EN
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      prod      <= '0;
`endif
    end else begin
      // Acceptance only happens when the old result is gone or leaving on this
      // edge, so loading here never overwrites an unconsumed result.
      if (accept && !is_mul) begin
        out       <= res_out;
        cout      <= res_cout;
        overflow  <= res_ovf;
        illegal   <= res_ill;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef ALU_ARITH_MUL_EN
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state <= MUL;
            mcand <= in1;
            prod  <= {{WIDTH{1'b0}}, in2};
            cnt   <= '0;
          end
        end
        MUL: begin
          prod <= {psum, prod[WIDTH-1:1]};
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle publishes the product; stay until it is taken.
          if (!out_valid) begin
            out       <= prod[WIDTH-1:0];
            cout      <= 1'b0;
            overflow  <= |prod[2*WIDTH-1:WIDTH];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_arith_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_arith_pipe
//
// Directed and randomized stimulus for alu_arith_pipe (WIDTH=32). A reference
// model computes each result from the opcode rules with plain integer
// arithmetic; accepted requests push into exp_q and a negedge monitor checks
// out_valid, in_ready and the result fields every cycle.
// Build with +define+ALU_ARITH_MUL_EN to include the multiplier scenarios.
// -----------------------------------------------------------------------------
module tb_alu_arith_pipe;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SEQ = 4'b0001;
  localparam logic [3:0] OP_SNE = 4'b1001;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SGT = 4'b0011;
  localparam logic [3:0] OP_SLE = 4'b1101;
  localparam logic [3:0] OP_SGE = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b0100;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       crtlSig;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             overflow;
  logic             illegal;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  alu_arith_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .crtlSig(crtlSig), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout), .overflow(overflow),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // scoreboard state
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  logic [WIDTH+2:0] exp_q[$];          // {illegal, overflow, cout, out}
  bit               mul_busy = 1'b0;
  int               mul_due  = 0;
  bit               rand_ready = 1'b0;
  logic             ev;
  logic             eir;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_mul_op(input logic [3:0] op);
`ifdef ALU_ARITH_MUL_EN
    return op == OP_MUL;
`else
    return (op == OP_MUL) && 1'b0;
`endif
  endfunction

  // Reference model: results from the opcode definitions in 64-bit arithmetic.
  function automatic logic [WIDTH+2:0] model(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    longint          sa, sb, r, smax, smin;
    longint unsigned ua, ub, p;
    logic [WIDTH-1:0] o;
    logic c, v, il;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    o = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      OP_ADD: begin
        p = ua + ub;
        o = p[WIDTH-1:0];
        c = (p >> WIDTH) != 0;
        r = sa + sb;
        v = (r > smax) || (r < smin);
      end
      OP_SUB: begin
        p = ua - ub;
        o = p[WIDTH-1:0];
        c = (ua >= ub);
        r = sa - sb;
        v = (r > smax) || (r < smin);
      end
      OP_SEQ: o = WIDTH'(sa == sb);
      OP_SNE: o = WIDTH'(sa != sb);
      OP_SLT: o = WIDTH'(sa <  sb);
      OP_SGT: o = WIDTH'(sa >  sb);
      OP_SLE: o = WIDTH'(sa <= sb);
      OP_SGE: o = WIDTH'(sa >= sb);
`ifdef ALU_ARITH_MUL_EN
      OP_MUL: begin
        p = ua * ub;
        o = p[WIDTH-1:0];
        v = (p >> WIDTH) != 0;
      end
`endif
      default: il = 1'b1;
    endcase
    return {il, v, c, o};
  endfunction

  // Monitor: away from the active edge, compare against the expected queue
  // and account for the transfers that the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      ev  = (exp_q.size() > 0) && !(mul_busy && (cyc < mul_due));
      eir = (!ev || out_ready) && !mul_busy;
      check("out_valid", 64'(out_valid), 64'(ev));
      check("in_ready", 64'(in_ready), 64'(eir));
      if (ev) check("result", 64'({illegal, overflow, cout, out}), 64'(exp_q[0]));
      if (ev && out_ready) begin
        void'(exp_q.pop_front());
        mul_busy = 1'b0;
      end
      if (in_valid && eir) begin
        exp_q.push_back(model(crtlSig, in1, in2));
        if (is_mul_op(crtlSig)) begin
          mul_busy = 1'b1;
          mul_due  = cyc + WIDTH + 1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    crtlSig  = op;
    in1      = a;
    in2      = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    check("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [WIDTH-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return WIDTH'($urandom_range(0, 8));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; crtlSig = '0; out_ready = 1'b1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back set ops on equal operands: 1,0,0,0,1,1
    send(OP_SEQ, 1, 1); send(OP_SNE, 1, 1); send(OP_SLT, 1, 1);
    send(OP_SGT, 1, 1); send(OP_SLE, 1, 1); send(OP_SGE, 1, 1);
    idle(2);

    // overflow/carry corners, signed compare, borrow, illegal opcodes
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    send(OP_SUB, 32'd3, 32'd5);
    send(OP_SUB, 32'h8000_0000, 32'h1);
    send(4'b1111, 32'h1234, 32'h5678);
    send(OP_MUL, 32'd7, 32'd6);
    idle(40);

    // back-pressure: result held, blocked request not taken, then swap
    out_ready = 1'b0;
    send(OP_ADD, 32'd5, 32'd6);
    in_valid = 1'b1; crtlSig = OP_SUB; in1 = 32'd100; in2 = 32'd1;
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    send(OP_SUB, 32'd100, 32'd1);
    send(OP_ADD, 32'd10, 32'd20);
    idle(2);

`ifdef ALU_ARITH_MUL_EN
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    idle(40);
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(40);
    // reset in the middle of a multiply: nothing may come out afterwards
    send(OP_MUL, 32'd3, 32'd3);
    idle(9);
    rst = 1'b1;
    exp_q.delete();
    mul_busy = 1'b0;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(40);
`endif

    // randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       send(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
        1, 2:    send(($urandom_range(0, 1) != 0) ? OP_ADD : OP_SUB,
                      rnd_operand(), rnd_operand());
        default: begin
          n = $urandom_range(0, 7);
          case (n)
            0: send(OP_SEQ, rnd_operand(), rnd_operand());
            1: send(OP_SNE, rnd_operand(), rnd_operand());
            2: send(OP_SLT, rnd_operand(), rnd_operand());
            3: send(OP_SGT, rnd_operand(), rnd_operand());
            4: send(OP_SLE, rnd_operand(), rnd_operand());
            5: send(OP_SGE, rnd_operand(), rnd_operand());
            6: send(OP_ADD, rnd_operand(), rnd_operand());
            default: send(OP_SUB, rnd_operand(), rnd_operand());
          endcase
        end
      endcase
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    // drain
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    // reset while a result is being held
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2);
    idle(1);
    rst = 1'b1;
    exp_q.delete();
    mul_busy = 1'b0;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
